// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: drives an 8-bit R-2R DAC trial code
// and resolves one bit per settle/decide pass using a synchronised comparator.
module sar_adc_ctrl #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       start,
  input  logic       cmp_in,
  output logic [7:0] dac_out,
  output logic       busy,
  output logic [7:0] result,
  output logic       result_valid
);

  // The settle window must swallow the two synchroniser stages plus margin.
  if (SETTLE_CYCLES < 3) begin : g_settle_too_short
    $error("sar_adc_ctrl: SETTLE_CYCLES must be at least 3");
  end

  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] DECIDE = 2'd2;

  logic [1:0]    state_r, state_s;
  logic [7:0]    approx_r, approx_s;
  logic [CW-1:0] count_r, count_s;
  logic [2:0]    idx_r, idx_s;
  logic [7:0]    dac_s, result_s;
  logic          busy_s, valid_s;
  logic          cmp_meta_r, cmp_s;
  logic [7:0]    trial_s, kept_s;

  // Two-flop synchroniser for the asynchronous comparator output.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cmp_meta_r <= 1'b0;
      cmp_s      <= 1'b0;
    end else begin
      cmp_meta_r <= cmp_in;
      cmp_s      <= cmp_meta_r;
    end
  end

  // Next-state and next-output computation for the SAR sequencer.
  always_comb begin
    state_s  = state_r;
    approx_s = approx_r;
    count_s  = count_r;
    idx_s    = idx_r;
    dac_s    = dac_out;
    result_s = result;
    busy_s   = busy;
    valid_s  = 1'b0;
    trial_s  = 8'd1 << idx_r;
    kept_s   = cmp_s ? approx_r : (approx_r & ~trial_s);
    case (state_r)
      IDLE: begin
        if (start) begin
          approx_s = 8'h80;
          dac_s    = 8'h80;
          idx_s    = 3'd7;
          count_s  = RELOAD;
          busy_s   = 1'b1;
          state_s  = SETTLE;
        end else begin
          state_s  = IDLE;
        end
      end
      SETTLE: begin
        if (count_r == {CW{1'b0}}) begin
          state_s = DECIDE;
        end else begin
          count_s = count_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DECIDE: begin
        // Only the cmp_s value seen in this cycle decides the trial bit.
        if (idx_r != 3'd0) begin
          approx_s = kept_s | (trial_s >> 1);
          dac_s    = kept_s | (trial_s >> 1);
          idx_s    = idx_r - 3'd1;
          count_s  = RELOAD;
          state_s  = SETTLE;
        end else begin
          approx_s = kept_s;
          dac_s    = kept_s;
          result_s = kept_s;
          valid_s  = 1'b1;
          busy_s   = 1'b0;
          state_s  = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_r      <= IDLE;
      approx_r     <= 8'h00;
      count_r      <= {CW{1'b0}};
      idx_r        <= 3'd0;
      dac_out      <= 8'h00;
      result       <= 8'h00;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state_r      <= state_s;
      approx_r     <= approx_s;
      count_r      <= count_s;
      idx_r        <= idx_s;
      dac_out      <= dac_s;
      result       <= result_s;
      busy         <= busy_s;
      result_valid <= valid_s;
    end
  end

endmodule

// File: doc/sar_adc_ctrl.md
SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 16, meaning clk cycles the R-2R DAC output settles before each comparator decision.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port nRST, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, conversion request, level-sampled in IDLE only.
REQ-005 The block SHALL have port cmp_in, input, 1, asynchronous external comparator output; 1 = analog input >= DAC voltage.
REQ-006 The block SHALL have port dac_out, output, 8, registered trial code to the parallel R-2R DAC.
REQ-007 The block SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 The block SHALL have port result, output, 8, last completed conversion code.
REQ-009 The block SHALL have port result_valid, output, 1, one-cycle pulse marking a new result.

Function
REQ-010 cmp_in SHALL pass through a 2-flop synchronizer; decisions SHALL use only the second stage (cmp_s).
REQ-011 SETTLE_CYCLES < 3 SHALL be rejected at elaboration, so that settle time covers the synchronizer delay.
REQ-012 The FSM SHALL have exactly three states: IDLE, SETTLE, DECIDE.
REQ-013 IDLE with start=1 at an edge: approx=0x80, dac_out=0x80, bit index=7, settle count=SETTLE_CYCLES-1, busy=1, go to SETTLE.
REQ-014 IDLE with start=0: state SHALL hold; dac_out, result and busy=0 SHALL hold.
REQ-015 SETTLE: count SHALL decrement each edge; at the edge where count==0, go to DECIDE. SETTLE therefore lasts SETTLE_CYCLES cycles.
REQ-016 DECIDE, cmp_s=1: the trial bit SHALL be kept.
REQ-017 DECIDE, cmp_s=0: the trial bit SHALL be cleared in approx.
REQ-018 DECIDE, index>0: decrement index, set the next lower bit in approx, drive dac_out=new approx, reload count=SETTLE_CYCLES-1, go to SETTLE.
REQ-019 DECIDE, index==0: result=final approx, dac_out=final approx, result_valid=1 for exactly one cycle, busy=0, go to IDLE.
REQ-020 Latency: with start sampled at edge E0, result_valid SHALL rise at edge E0+8*(SETTLE_CYCLES+1); for default 16 this is E0+136.
REQ-021 start while busy=1 SHALL be ignored; the conversion SHALL continue unchanged.
REQ-022 start held high SHALL give back-to-back conversions: the IDLE cycle that carries result_valid samples start, giving a period of 8*(SETTLE_CYCLES+1)+1 cycles.
REQ-023 dac_out SHALL hold the final result code between conversions.
REQ-024 result SHALL change only on the result_valid edge.
REQ-025 Changes on cmp_in during SETTLE SHALL not affect approx; only the DECIDE-cycle cmp_s value counts.

Reset
REQ-026 nRST=0 SHALL immediately force state=IDLE, dac_out=0x00, result=0x00, result_valid=0, busy=0, approx=0, count=0, index=0, synchronizer flops=0.
REQ-027 Reset mid-conversion SHALL abort the conversion; no result_valid SHALL follow.
REQ-028 After nRST rises, the first conversion SHALL start only on a start sampled in IDLE.

Verification
Ideal comparator model for all scenarios: cmp_in = (vin_code >= dac_out), SETTLE_CYCLES=16 unless stated.
REQ-029 vin=0xA5, single start pulse -> dac_out sequence 80,C0,A0,B0,A8,A4,A6,A5; result=0xA5; result_valid at E0+136; busy high E0..E0+136.
REQ-030 vin=0x00 -> result 0x00; vin=0xFF -> result 0xFF; both with the same latency.
REQ-031 Extra start pulses at E0+10 and E0+100 -> single result_valid at E0+136; result unchanged from the uninterrupted case.
REQ-032 nRST low at E0+50 -> dac_out=0, busy=0, no result_valid; a new start after release converts correctly.
REQ-033 start held high with vin=0x3C -> result_valid pulses every 137 cycles, each with result=0x3C.
REQ-034 SETTLE_CYCLES=3, vin=0x81 -> result 0x81 with result_valid at E0+32; SETTLE_CYCLES=2 -> elaboration fails.
